bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_if.sv | 33 +++
 rtl/bus_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_if
// Description : Request/grant bundle between the requesters and the
//               round-robin bus arbiter that drives the shared mux select.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int SEL_WIDTH = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   grant;
    logic [SEL_WIDTH-1:0] sel;
    logic                 bus_valid;

    // Requester side: raises requests, observes the grant
    modport master (
        output req,
        input  grant,
        input  sel,
        input  bus_valid
    );

    // Arbiter side: samples requests, drives grant and mux select
    modport slave (
        input  req,
        output grant,
        output sel,
        output bus_valid
    );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Round-robin arbiter for a shared tri-state bus mux. Grants
//               one requester at a time, limits tenure to MAX_HOLD cycles
//               when others wait, and inserts a one-cycle turnaround with no
//               grant between owners so bus drivers never overlap.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int SEL_WIDTH = $clog2(NUM_REQ),
    parameter int MAX_HOLD  = 4
) (
    input  logic         clk,
    input  logic         reset,
    bus_arbiter_if.slave bus
);

    localparam int c_HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   w_grant_nxt;
    logic [SEL_WIDTH-1:0] r_sel;
    logic [SEL_WIDTH-1:0] w_sel_nxt;
    logic                 r_valid;
    logic                 w_valid_nxt;
    logic [SEL_WIDTH-1:0] r_ptr;
    logic [SEL_WIDTH-1:0] w_ptr_nxt;
    logic [c_HOLD_W-1:0]  r_hold;
    logic [c_HOLD_W-1:0]  w_hold_nxt;

    logic                 w_any;
    logic [SEL_WIDTH-1:0] w_winner;
    logic [NUM_REQ-1:0]   w_owner_mask;
    logic                 w_owner_req;
    logic                 w_others;
    logic                 w_hold_full;

    // First set request scanning upward from ptr with wraparound. The loop
    // runs from the farthest offset down so the nearest match wins.
    function automatic logic [SEL_WIDTH-1:0] f_pick(
        input logic [NUM_REQ-1:0]   req_v,
        input logic [SEL_WIDTH-1:0] ptr_v
    );
        logic [SEL_WIDTH-1:0] idx;
        f_pick = ptr_v;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            // NUM_REQ is a power of two, so truncation is the modulo wrap
            idx = ptr_v + SEL_WIDTH'(i);
            if (req_v[idx]) begin
                f_pick = idx;
            end
        end
    endfunction

    assign w_any        = |bus.req;
    assign w_winner     = f_pick(bus.req, r_ptr);
    assign w_owner_mask = NUM_REQ'(1) << r_sel;
    assign w_owner_req  = bus.req[r_sel];
    assign w_others     = |(bus.req & ~w_owner_mask);
    assign w_hold_full  = (r_hold == c_HOLD_LAST);

    // Next-state and next-output decode; every path starts from "hold"
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_valid_nxt = r_valid;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        case (r_state)
            IDLE, TURN: begin
                // Turnaround arbitrates exactly like idle, using the ptr
                // advanced when the previous owner left
                if (w_any) begin
                    w_state_nxt = OWN;
                    w_grant_nxt = NUM_REQ'(1) << w_winner;
                    w_sel_nxt   = w_winner;
                    w_valid_nxt = 1'b1;
                    w_hold_nxt  = '0;
                end else begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                    w_valid_nxt = 1'b0;
                end
            end
            OWN: begin
                // Release on drop, or on preemption once the tenure is used
                if (!w_owner_req || (w_hold_full && w_others)) begin
                    w_state_nxt = TURN;
                    w_grant_nxt = '0;
                    w_valid_nxt = 1'b0;
                    w_ptr_nxt   = r_sel + SEL_WIDTH'(1);
                end else if (!w_hold_full) begin
                    w_hold_nxt  = r_hold + c_HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset wins over any transition
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_sel   <= w_sel_nxt;
            r_valid <= w_valid_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    assign bus.grant     = r_grant;
    assign bus.sel       = r_sel;
    assign bus.bus_valid = r_valid;

endmodule
`default_nettype wire
